// File: rtl/instr_fetch_seq.sv
// Instruction fetch/sequencing: owns the PC, fetches over a req/ack handshake,
// holds each instruction for the datapath. Optional J support under IFU_JUMP_EN.
module instr_fetch_seq #(
  parameter int unsigned       PC_W     = 32,
  parameter logic [PC_W-1:0]   RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  input  logic             stall,
  input  logic             branch,
  input  logic             zero,
  output logic             instr_valid,
  output logic [5:0]       opCode,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       shamt,
  output logic [5:0]       funct,
  output logic [31:0]      imm_sext,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  pc_plus4
`ifdef IFU_JUMP_EN
  ,
  output logic             jump_taken
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t          state, state_nxt;
  logic [31:0]     ir;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_nxt;
  logic [PC_W-1:0] br_off;
  logic            advance;

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign pc_plus4  = pc_q + PC_W'(4);

  assign opCode   = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign shamt    = ir[10:6];
  assign funct    = ir[5:0];
  assign imm_sext = {{16{ir[15]}}, ir[15:0]};

  // Branch offset sign-extended to the PC width so wrap is modulo 2^PC_W.
  assign br_off = PC_W'($signed(imm_sext)) << 2;

`ifdef IFU_JUMP_EN
  logic is_jump;
  assign is_jump    = (ir[31:26] == 6'b000010);
  assign jump_taken = advance && is_jump;
`endif

  always_comb begin
    pc_nxt = pc_plus4;
`ifdef IFU_JUMP_EN
    if (is_jump)
      pc_nxt = {pc_plus4[PC_W-1:28], ir[25:0], 2'b00};
    else
`endif
    if (branch && zero)
      pc_nxt = pc_plus4 + br_off;
  end

  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    advance     = 1'b0;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) state_nxt = HOLD;
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (!stall) begin
          advance   = !reset;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc_q  <= RESET_PC;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == FETCH && imem_ack) ir <= imem_rdata;
      if (advance) pc_q <= {pc_nxt[PC_W-1:2], 2'b00};
    end
  end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Bench for instr_fetch_seq: directed scenarios then randomized traffic,
// all checked against a transaction-level model of the fetch sequencer.
module tb_instr_fetch_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic        stall = 1'b0, branch = 1'b0, zero = 1'b0;
  logic        instr_valid;
  logic [5:0]  opCode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] imm_sext, pc, pc_plus4;
`ifdef IFU_JUMP_EN
  logic        jump_taken, w_jump;
`endif

  logic        w_req, w_ack, w_valid;
  logic [31:0] w_addr, w_imm, w_pc, w_pc4;
  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
  assign w_ack = w_req;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0020;

  always #5 clk = ~clk;

  instr_fetch_seq #(.PC_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .branch(branch), .zero(zero), .instr_valid(instr_valid),
    .opCode(opCode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .funct(funct), .imm_sext(imm_sext), .pc(pc), .pc_plus4(pc_plus4)
`ifdef IFU_JUMP_EN
    , .jump_taken(jump_taken)
`endif
  );

  instr_fetch_seq #(.PC_W(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(reset), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(NOP), .stall(1'b0),
    .branch(1'b0), .zero(1'b0), .instr_valid(w_valid),
    .opCode(w_op), .rs(w_rs), .rt(w_rt), .rd(w_rd), .shamt(w_shamt),
    .funct(w_funct), .imm_sext(w_imm), .pc(w_pc), .pc_plus4(w_pc4)
`ifdef IFU_JUMP_EN
    , .jump_taken(w_jump)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = waiting one cycle after reset, 1 = awaiting
  // the word at m_pc, 2 = presenting m_ir.
  int          m_phase = 0;
  bit          m_init = 0;
  logic [31:0] m_pc = '0, m_ir = '0;

  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                             input logic br, input logic z);
    int off;
    off = $signed(w[15:0]) * 4;
`ifdef IFU_JUMP_EN
    if ((w >> 26) == 2) return ((p + 4) & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 4);
`endif
    if (br && z) return p + 4 + 32'(off);
    return p + 4;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_init  <= 1'b1;
      m_phase <= 0;
      m_pc    <= 32'h0;
      m_ir    <= 32'h0;
    end else if (m_init) begin
      if (m_phase == 0) m_phase <= 1;
      else if (m_phase == 1) begin
        if (imem_ack) begin
          m_ir    <= imem_rdata;
          m_phase <= 2;
        end
      end else if (!stall) begin
        m_pc    <= model_next(m_pc, m_ir, branch, zero);
        m_phase <= 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("req",      32'(imem_req),    32'(m_phase == 1));
      chk("valid",    32'(instr_valid), 32'(m_phase == 2));
      chk("addr",     imem_addr, m_pc);
      chk("pc",       pc,        m_pc);
      chk("pc_plus4", pc_plus4,  m_pc + 4);
      chk("opCode",   32'(opCode), m_ir >> 26);
      chk("rs",       32'(rs),     (m_ir >> 21) & 31);
      chk("rt",       32'(rt),     (m_ir >> 16) & 31);
      chk("rd",       32'(rd),     (m_ir >> 11) & 31);
      chk("shamt",    32'(shamt),  (m_ir >> 6) & 31);
      chk("funct",    32'(funct),  m_ir & 63);
      chk("imm_sext", imm_sext,    32'($signed(m_ir[15:0])));
`ifdef IFU_JUMP_EN
      chk("jump_taken", 32'(jump_taken),
          32'(m_phase == 2 && !stall && !reset && (m_ir >> 26) == 2));
`endif
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a request, check its address, ack after dly cycles.
  task automatic fetch(input logic [31:0] w, input int dly, input logic [31:0] ea, input string nm);
    int n = 0;
    while (!imem_req && n < 20) begin
      tick;
      n++;
    end
    chk({nm, "_req"}, 32'(imem_req), 32'h1);
    if (!imem_req) return;
    chk({nm, "_addr"}, imem_addr, ea);
    repeat (dly) tick;
    imem_ack   = 1'b1;
    imem_rdata = w;
    tick;
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
  endtask

  initial begin
    tick;
    tick;
    chk("rst_req",   32'(imem_req), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_pc",    pc, 32'h0);
    chk("rst_imm",   imm_sext, 32'h0);
    chk("rst_wpc",   w_pc, 32'hFFFF_FFFC);
    reset = 1'b0;
    tick;
    chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    chk("wrap_pc4",   w_pc4, 32'h0);

    fetch(32'h2008_0005, 0, 32'h0, "addi");
    chk("addi_op",  32'(opCode), 32'h08);
    chk("addi_rt",  32'(rt), 32'd8);
    chk("addi_imm", imm_sext, 32'd5);
    fetch(32'h0109_5020, 0, 32'h4, "rtype");
    chk("rtype_op", 32'(opCode), 32'h00);
    chk("rtype_rd", 32'(rd), 32'd10);
    chk("rtype_fn", 32'(funct), 32'h20);
    chk("wrap_pc1", w_pc, 32'h0);
    chk("wrap_vld", 32'(w_valid), 32'h1);

    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("stall_pc",  pc, 32'h4);
      chk("stall_rd",  32'(rd), 32'd10);
      chk("stall_req", 32'(imem_req), 32'h0);
      chk("stall_vld", 32'(instr_valid), 32'h1);
    end
    stall = 1'b0;
    fetch(NOP, 0, 32'h8, "post_stall");
    fetch(NOP, 1, 32'hC, "seq_c");

    fetch(32'h1000_FFFE, 0, 32'h10, "beq_t");
    branch = 1'b1;
    zero   = 1'b1;
    fetch(NOP, 0, 32'hC, "beq_taken");
    branch = 1'b0;
    zero   = 1'b0;
    fetch(32'h1000_FFFE, 2, 32'h10, "beq_n");
    branch = 1'b1;
    fetch(NOP, 0, 32'h14, "beq_not");
    branch = 1'b0;

    tick;
    chk("mid_req", 32'(imem_req), 32'h1);
    chk("mid_addr", imem_addr, 32'h18);
    tick;
    reset = 1'b1;
    tick;
    chk("rst2_req", 32'(imem_req), 32'h0);
    chk("rst2_pc",  pc, 32'h0);
    reset      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick;
    imem_ack = 1'b0;
    chk("late_vld", 32'(instr_valid), 32'h0);
    fetch(NOP, 0, 32'h0, "refetch");
    chk("refetch_fn", 32'(funct), 32'h20);

    for (int a = 4; a < 32'h20; a += 4) fetch(NOP, 0, 32'(a), "walk");
    fetch(32'h0800_0040, 0, 32'h20, "jword");
`ifdef IFU_JUMP_EN
    chk("jump_pulse", 32'(jump_taken), 32'h1);
    tick;
    chk("jump_drop", 32'(jump_taken), 32'h0);
    fetch(NOP, 0, 32'h100, "jump_tgt");
`else
    fetch(NOP, 0, 32'h24, "jump_seq");
`endif

    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom % 150) == 0;
      stall      = ($urandom % 3) == 0;
      branch     = $urandom % 2;
      zero       = $urandom % 2;
      imem_ack   = $urandom % 2;
      imem_rdata = (($urandom % 4) == 0) ? {6'b000010, 26'($urandom)} : 32'($urandom);
      tick;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_seq.md
Name: instr_fetch_seq

Overview:
- Instruction fetch and sequencing block that produces the 6-bit opcode consumed by the control unit. Also exports the other instruction fields used by the datapath.
- Owns the PC and fetches 32-bit words from instruction memory over a req/ack handshake.
- Holds each instruction stable while the datapath executes it.
- Computes the next PC from the control unit's Branch output and the ALU zero flag.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- PC_W, 32, PC and instruction-memory address width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  PC_W  fetch address, equal to the current PC.
- imem_ack  input  1  memory has valid data on imem_rdata this cycle.
- imem_rdata  input  32  instruction word.
- stall  input  1  datapath not ready; hold the current instruction.
- branch  input  1  Branch from the control unit.
- zero  input  1  ALU zero flag.
- instr_valid  output  1  decoded fields below are valid.
- opCode  output  6  instr[31:26], to the control unit.
- rs  output  5  instr[25:21].
- rt  output  5  instr[20:16].
- rd  output  5  instr[15:11].
- shamt  output  5  instr[10:6].
- funct  output  6  instr[5:0].
- imm_sext  output  32  instr[15:0] sign-extended.
- pc  output  PC_W  address of the held instruction.
- pc_plus4  output  PC_W  pc + 4.

Behaviour:
- States:
  - IDLE: one cycle after reset.
  - FETCH: request outstanding.
  - HOLD: instruction presented.
- Reset (synchronous, any state, including mid-fetch):
  - pc=RESET_PC, instruction register=0, state=IDLE.
  - imem_req=0, instr_valid=0.
  - All field outputs 0.
  - A late imem_ack arriving after reset is ignored unless state is FETCH.
- IDLE -> FETCH unconditionally on the next edge.
- FETCH:
  - imem_req=1; imem_addr=pc, held stable until ack.
  - On imem_ack=1: capture imem_rdata into the instruction register, go to HOLD.
  - Ack may arrive in the first FETCH cycle (zero-wait memory); minimum fetch is 1 cycle.
- HOLD:
  - imem_req=0; instr_valid=1; fields are driven combinationally from the instruction register.
  - stall=1: remain in HOLD; pc and fields unchanged.
  - stall=0: at the edge, pc <= next_pc, state <= FETCH, instr_valid drops to 0 the next cycle.
- next_pc:
  - branch & zero: pc_plus4 + (imm_sext << 2).
  - otherwise: pc_plus4.
  - branch and zero are sampled only on the advancing edge (HOLD & !stall); ignored in other states.
- Arithmetic:
  - Modulo 2^PC_W.
  - 32'hFFFF_FFFC + 4 wraps to 0.
  - Negative branch offsets wrap the same way.
  - pc[1:0] is always 00; imem_addr low bits never nonzero.
- Throughput with no stall and 1-cycle ack: one instruction per 2 cycles (FETCH, HOLD).
- Unknown opcodes are not checked here; the block passes them through.
- imem_ack outside FETCH is ignored.

Optional Feature:
- Macro: IFU_JUMP_EN.
- Defined: opcode 6'b000010 (J) in HOLD, on advance, sets next_pc = {pc_plus4[31:28], instr[25:0], 2'b00}.
  - Jump takes priority over branch.
  - An extra output jump_taken (1 bit) pulses for one cycle on the advancing edge of a J.
- Not defined: J is treated like any other opcode (next_pc follows the branch/sequential rule) and jump_taken is absent.

Test Plan:
- Reset, then ack each request in the same cycle with words 0x2008_0005 (addi), 0x0109_5020 (R-type):
  - imem_addr sequence is 0x0, 0x4.
  - opCode 0x08, rt=8, imm_sext=5 valid in the first HOLD.
  - Then opCode 0x00, rd=10, funct=0x20.
- HOLD with stall=1 for 5 cycles, then release:
  - fields and pc stable for all 5 cycles; no imem_req during the stall.
  - Next fetch at pc+4.
- BEQ at pc=0x10 with imm=0xFFFE, branch=1, zero=1 -> next imem_addr=0x0C.
- Same BEQ with zero=0 -> next imem_addr=0x14.
- reset asserted during FETCH with ack delayed 3 cycles:
  - imem_req=0 and pc=RESET_PC the cycle after reset.
  - The late ack is ignored; a fresh fetch at RESET_PC follows.
- RESET_PC=32'hFFFF_FFFC with a non-branch instruction -> next imem_addr=0x0000_0000.
- IFU_JUMP_EN defined: J word 0x0800_0040 at pc=0x20 -> next imem_addr=0x100 and jump_taken pulses once.
- IFU_JUMP_EN undefined: the same J word -> next imem_addr=0x24.
